// File: rtl/prim_shadow_pkg.sv
// rtl/prim_shadow_pkg.sv - shared types and helpers for multi-write shadowed registers
// Purpose: phase sizing, NumWrites legality check and error-cause encoding
//          shared by prim_subreg_shadow_multi and its comparator.
// Ports:   none (package).
package prim_shadow_pkg;

    localparam int unsigned MinNumWrites = 2;
    localparam int unsigned MaxNumWrites = 4;

    // Widest phase register any legal NumWrites can need.
    localparam int unsigned MaxPhaseW = $clog2(MaxNumWrites);
    typedef logic [MaxPhaseW-1:0] phase_t;

    // Phase counter width for a given NumWrites: phases 0..NumWrites-1.
    function automatic int unsigned phase_width(input int unsigned num_writes);
        return $clog2(num_writes);
    endfunction

    function automatic bit num_writes_ok(input int unsigned num_writes);
        return (num_writes >= MinNumWrites) && (num_writes <= MaxNumWrites);
    endfunction

    typedef enum logic [1:0] {
        ErrNone    = 2'd0,
        ErrUpdate  = 2'd1,
        ErrStorage = 2'd2
    } err_cause_e;

endpackage

// File: rtl/prim_shadow_cmp.sv
// rtl/prim_shadow_cmp.sv - complement-equality comparator
// Purpose: eq_o is high when a_i equals the bitwise complement of b_inv_i.
// Ports:   a_i     [DW] plain value
//          b_inv_i [DW] value held in 1's complement
//          eq_o         match flag
module prim_shadow_cmp #(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_inv_i,
    output logic          eq_o
);

    assign eq_o = (a_i == ~b_inv_i);

endmodule

// File: rtl/prim_subreg_shadow_multi.sv
// rtl/prim_subreg_shadow_multi.sv - shadowed CSR field committing after NumWrites identical writes
// Purpose: committed/staged/shadow storage with multi-phase SW write, trusted HW
//          write bypass, sticky storage error and saturating error counter.
//          Optional macro PRIM_SHADOW_TIMEOUT_EN adds an idle timeout that
//          returns the write sequence to phase 0.
// Ports:   clk_i, rst_i (async, active-high)
//          re, we, wd[DW]        SW read strobe, write strobe, write data
//          de, d[DW]             HW write enable and data
//          qe, q[DW], qs[DW]     update pulse, committed value (HW / read mux)
//          phase                 current write phase
//          err_update            pulse on mismatched confirm write
//          err_storage           combinational shadow/committed disagreement
//          err_storage_sticky    latched err_storage
//          err_cnt[CntW]         saturating count of err_storage cycles
module prim_subreg_shadow_multi
    import prim_shadow_pkg::*;
#(
    parameter int unsigned    DW            = 32,
    parameter int unsigned    NumWrites     = 2,
    parameter logic [DW-1:0]  RESVAL        = '0,
    parameter int unsigned    CntW          = 8,
    parameter int unsigned    TimeoutCycles = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            re,
    input  logic                            we,
    input  logic [DW-1:0]                   wd,
    input  logic                            de,
    input  logic [DW-1:0]                   d,
    output logic                            qe,
    output logic [DW-1:0]                   q,
    output logic [DW-1:0]                   qs,
    output logic [$clog2(NumWrites)-1:0]    phase,
    output logic                            err_update,
    output logic                            err_storage,
    output logic                            err_storage_sticky,
    output logic [CntW-1:0]                 err_cnt
);

    localparam int unsigned PW = phase_width(NumWrites);
    localparam logic [PW-1:0] LastPhase = PW'(NumWrites - 1);

    if (!num_writes_ok(NumWrites) || TimeoutCycles == 0 || DW == 0 || CntW == 0) begin : gen_bad_params
        $error("prim_subreg_shadow_multi: illegal parameter set");
    end

    logic [DW-1:0]   committed_q, committed_d;
    logic [DW-1:0]   staged_q, staged_d;
    logic [DW-1:0]   shadow_q, shadow_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            qe_q, qe_d;
    logic            err_update_q, err_update_d;
    logic            sticky_q, sticky_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wd_match;
    logic            store_ok;
    logic            timeout;
    err_cause_e      cause;

    // Confirm writes compare against the complemented staged copy; storage
    // integrity compares committed against the complemented shadow copy.
    prim_shadow_cmp #(.DW(DW)) u_cmp_update (
        .a_i     (wd),
        .b_inv_i (staged_q),
        .eq_o    (wd_match)
    );

    prim_shadow_cmp #(.DW(DW)) u_cmp_storage (
        .a_i     (committed_q),
        .b_inv_i (shadow_q),
        .eq_o    (store_ok)
    );

`ifdef PRIM_SHADOW_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TimeoutCycles + 1);
    logic [IdleW-1:0] idle_q, idle_d;

    // Counts only idle cycles spent mid-sequence; any strobe restarts it.
    always_comb begin
        idle_d  = '0;
        timeout = 1'b0;
        if (!(we || de || re) && (phase_q != '0)) begin
            if (idle_q == IdleW'(TimeoutCycles - 1)) begin
                timeout = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        committed_d = committed_q;
        staged_d    = staged_q;
        shadow_d    = shadow_q;
        phase_d     = phase_q;
        qe_d        = 1'b0;
        cause       = ErrNone;

        if (de) begin
            // Trusted HW write resynchronises all three copies; a same-cycle
            // SW write is silently dropped.
            committed_d = d;
            shadow_d    = ~d;
            staged_d    = ~d;
            phase_d     = '0;
            qe_d        = 1'b1;
        end else if (we) begin
            if (phase_q == '0) begin
                staged_d = ~wd;
                phase_d  = PW'(1);
            end else if (!wd_match) begin
                cause   = ErrUpdate;
                phase_d = '0;
            end else if (phase_q == LastPhase) begin
                committed_d = wd;
                shadow_d    = staged_q;
                phase_d     = '0;
                qe_d        = 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end else if (re || timeout) begin
            phase_d = '0;
        end

        err_update_d = (cause == ErrUpdate);
        sticky_d     = sticky_q | err_storage;
        cnt_d        = cnt_q;
        if (err_storage && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            committed_q  <= RESVAL;
            staged_q     <= ~RESVAL;
            shadow_q     <= ~RESVAL;
            phase_q      <= '0;
            qe_q         <= 1'b0;
            err_update_q <= 1'b0;
            sticky_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            committed_q  <= committed_d;
            staged_q     <= staged_d;
            shadow_q     <= shadow_d;
            phase_q      <= phase_d;
            qe_q         <= qe_d;
            err_update_q <= err_update_d;
            sticky_q     <= sticky_d;
            cnt_q        <= cnt_d;
        end
    end

    assign err_storage        = ~store_ok;
    assign q                  = committed_q;
    assign qs                 = committed_q;
    assign phase              = phase_q;
    assign qe                 = qe_q;
    assign err_update         = err_update_q;
    assign err_storage_sticky = sticky_q;
    assign err_cnt            = cnt_q;

endmodule

// File: doc/prim_subreg_shadow_multi.md
Name: prim_subreg_shadow_multi

Overview:
Generalised shadowed register slice for the register file. A value commits only after NumWrites identical software writes in consecutive phases (2..4), instead of a fixed two-phase write. Staged and shadow copies are held in 1's complement. Adds trusted hardware-write bypass, sticky error flags and a saturating storage-error counter. Instantiated per security-critical CSR field; outputs feed hardware and the register read mux.

Parameters:
DW, 32, data width (1..32)
NumWrites, 2, identical SW writes required to commit (2..4)
RESVAL, '0, committed reset value, DW bits
CntW, 8, width of storage-error counter
TimeoutCycles, 1024, idle cycles before phase auto-clear (used only with PRIM_SHADOW_TIMEOUT_EN)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
re  input  1  SW read strobe; clears phase
we  input  1  SW write strobe
wd  input  DW  SW write data
de  input  1  HW write enable (trusted, bypasses phases)
d  input  DW  HW write data
qe  output  1  one-cycle pulse, q updated this cycle
q  output  DW  committed value to HW
qs  output  DW  committed value to read mux
phase  output  $clog2(NumWrites)  current phase
err_update  output  1  one-cycle pulse, mismatched phase write
err_storage  output  1  combinational: ~shadow != committed
err_storage_sticky  output  1  latched err_storage, cleared by reset only
err_cnt  output  CntW  saturating count of cycles with err_storage=1

Behaviour:
- Interface: one clock clk_i; reset rst_i is asynchronous and active-high.
- Reset: committed=RESVAL; staged=shadow=~RESVAL; phase=0; qe=0; err_update=0; sticky=0; err_cnt=0. Reset mid-sequence discards partial writes.
- Phase states: P0 (idle), P1..P(NumWrites-1) (confirming).
- SW write in P0: staged<=~wd, phase<=1.
- SW write in Pk (0<k<NumWrites-1): ~staged==wd -> phase<=k+1; else err_update pulse, phase<=0, staged unchanged.
- SW write in P(NumWrites-1): match -> committed<=wd, shadow<=staged, phase<=0, qe=1 next cycle with new q; mismatch -> err_update, phase<=0, no commit.
- err_update, qe are registered: asserted the cycle after the triggering edge, for exactly one cycle.
- re without we: phase<=0. we and re same cycle: write wins, re ignored.
- de (any phase): committed<=d, shadow<=~d, staged<=~d, phase<=0, qe pulse. de and we same cycle: SW write dropped, no err_update.
- err_storage sets sticky; err_cnt increments each such cycle, saturates at all-ones, never wraps.
- q==qs==committed always.

Optional Feature:
PRIM_SHADOW_TIMEOUT_EN: defined -> idle counter ($clog2(TimeoutCycles+1) bits) runs while phase!=0, resets on any we/de/re; reaching TimeoutCycles forces phase<=0 (no error). Undefined -> no counter, phase held indefinitely.

Decomposition:
- Package prim_shadow_pkg: phase typedef sized from NumWrites, NumWrites legality check constant, error-cause enum (ErrNone, ErrUpdate, ErrStorage).
- Sub-module prim_shadow_cmp: DW-wide complement-equality comparator, reused for update and storage checks.

Test Plan:
- NumWrites=3, writes 0xA5A5_0001 x3 -> phase 1,2,0; qe pulse after third; q=0xA5A5_0001; no errors.
- NumWrites=3, writes 0x1, 0x1, 0x2 -> err_update one pulse, phase=0, q remains RESVAL.
- Write 0x5 in P0 then re -> phase=0; next write 0x5 restarts at P1, no commit.
- de=1,d=0xFFFF_0000 with simultaneous we in P1 -> q=0xFFFF_0000, qe pulse, phase=0, err_update=0.
- Force shadow bit flip -> err_storage=1, sticky=1, err_cnt counts and saturates at 255 (CntW=8); sticky clears only on rst_i.
- With PRIM_SHADOW_TIMEOUT_EN, TimeoutCycles=16: one write, idle 16 cycles -> phase=0; without macro phase stays 1.
